// File: rtl/systolic_sequencer.sv
// systolic_sequencer: runs one job through the 8x8 bit-serial OR-AND array.
// It packs the operand byte stream into (op1, op2) pairs, flushes the pipeline,
// shifts the accumulators out through readout into a result buffer, and then
// drains that buffer over a valid/ready port.
module systolic_sequencer #(
    parameter int N     = 8,
    parameter int PAIRS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] arr_in1,
    output logic [7:0] arr_in2,
    output logic       arr_readout,
    input  logic [7:0] arr_out,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam int BW = $clog2(2 * PAIRS + 1);
    localparam int CW = $clog2(2 * N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [BW-1:0] byte_cnt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] rd_idx;
    logic [7:0]    op1_q;
    logic [7:0]    res_buf [N];

    logic run;
    logic accept;
    logic last_byte;
    logic out_fire;
    logic last_word;

    // ena low is treated exactly like reset
    assign run       = rst_n & ena;
    assign accept    = in_valid & in_ready;
    assign last_byte = accept && (byte_cnt == BW'(2 * PAIRS - 1));
    assign out_fire  = out_valid & out_ready;
    assign last_word = out_fire && (rd_idx == IW'(N - 1));

    // done is decoded from registered state so it lands on the accepting handshake
    assign done     = run & last_word;
    assign out_data = res_buf[rd_idx];

    // job phase sequencing; FLUSH and READ lengths come from the phase counter
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)                   state_nxt = S_LOAD;
            S_LOAD:  if (last_byte)               state_nxt = S_FLUSH;
            S_FLUSH: if (cnt == CW'(N))           state_nxt = S_READ;
            S_READ:  if (cnt == CW'(2 * N - 1))   state_nxt = S_DRAIN;
            S_DRAIN: if (last_word)               state_nxt = S_IDLE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    // state, counters, pair packer and registered control outputs
    always_ff @(posedge clk) begin
        if (!run) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            cnt         <= '0;
            rd_idx      <= '0;
            op1_q       <= 8'h00;
            arr_in1     <= 8'h00;
            arr_in2     <= 8'h00;
            arr_readout <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready    <= (state_nxt == S_LOAD);
            out_valid   <= (state_nxt == S_DRAIN);
            arr_readout <= (state_nxt == S_READ);
            busy        <= (state_nxt != S_IDLE);

            // phase counter restarts on every state change
            if (state_nxt != state)
                cnt <= '0;
            else if (state == S_FLUSH || state == S_READ)
                cnt <= cnt + 1'b1;

            // even bytes are op1, odd bytes complete a pair
            if (accept) begin
                byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                if (!byte_cnt[0])
                    op1_q <= in_data;
            end

            // a pair is presented for exactly one cycle; gaps inject zero pairs
            arr_in1 <= (accept && byte_cnt[0]) ? op1_q   : 8'h00;
            arr_in2 <= (accept && byte_cnt[0]) ? in_data : 8'h00;

            if (out_fire)
                rd_idx <= last_word ? '0 : rd_idx + 1'b1;
        end
    end

    // capture readout words; odd READ offsets carry accumulators, even ones flushed zeros
    always_ff @(posedge clk) begin
        if (!run) begin
            for (int k = 0; k < N; k++)
                res_buf[k] <= 8'h00;
        end else if (state == S_READ && cnt[0]) begin
            res_buf[IW'(cnt >> 1)] <= arr_out;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: drives jobs through systolic_sequencer with a
// behavioural OR-AND array attached, and checks every output each cycle
// against a phase-schedule model, plus literal expectations per job.
module tb_systolic_sequencer;

    localparam int N = 8;
    localparam int P = 2;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, arr_readout, out_valid, busy, done;
    logic [7:0] arr_in1, arr_in2, arr_out, out_data;

    always #5 clk = ~clk;

    systolic_sequencer #(.N(N), .PAIRS(P)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .arr_in1(arr_in1), .arr_in2(arr_in2), .arr_readout(arr_readout),
        .arr_out(arr_out), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural array: 8 bit lanes handled bytewise, N cells each.
    // Normal mode: operands ripple one cell per cycle, acc |= op1 & op2.
    // Readout mode: (acc, out1) of all cells form one 2N-deep shift chain.
    logic [7:0] a_acc [N];
    logic [7:0] a_o1  [N];
    logic [7:0] a_o2  [N];
    assign arr_out = a_o1[N-1];

    always @(posedge clk) begin
        if (!rst_n || !ena) begin
            for (int i = 0; i < N; i++) begin
                a_acc[i] <= 8'h00; a_o1[i] <= 8'h00; a_o2[i] <= 8'h00;
            end
        end else if (arr_readout) begin
            a_acc[0] <= 8'h00;
            for (int i = 1; i < N; i++) a_acc[i] <= a_o1[i-1];
            for (int i = 0; i < N; i++) begin
                a_o1[i] <= a_acc[i]; a_o2[i] <= 8'h00;
            end
        end else begin
            a_o1[0]  <= arr_in1;
            a_o2[0]  <= arr_in2;
            a_acc[0] <= a_acc[0] | (arr_in1 & arr_in2);
            for (int i = 1; i < N; i++) begin
                a_o1[i]  <= a_o1[i-1];
                a_o2[i]  <= a_o2[i-1];
                a_acc[i] <= a_acc[i] | (a_o1[i-1] & a_o2[i-1]);
            end
        end
    end

    // Model: ms 0=idle 1=load 2=after last byte; m_d = cycles since that byte.
    int         ms = 0;
    int         m_nb = 0, m_d = 0, m_hs = 0, cyc = 0;
    logic [7:0] m_op1 = 0, m_pin1 = 0, m_pin2 = 0, m_acc = 0, m_out = 0;
    bit         ro_exp, ov_exp, dn_exp;

    // per-job observations for the literal checks
    int         j_ta = 0, j_ro_first = -1, j_ro_cnt = 0, j_ov_first = -1;
    int         j_hs = 0, j_done = 0, j_nz = 0;
    logic [7:0] j_words [$];

    int rdy_mode = 0;

    // compare every output each cycle, then advance the model on this cycle's inputs
    always @(negedge clk) begin
        cyc++;
        ro_exp = (ms == 2) && (m_d >= N + 2) && (m_d <= 3 * N + 1);
        ov_exp = (ms == 2) && (m_d >= 3 * N + 2);
        dn_exp = ov_exp && out_ready && (m_hs == N - 1) && rst_n && ena;
        check("busy",        busy,        ms != 0);
        check("in_ready",    in_ready,    ms == 1);
        check("arr_in1",     arr_in1,     m_pin1);
        check("arr_in2",     arr_in2,     m_pin2);
        check("arr_readout", arr_readout, ro_exp);
        check("out_valid",   out_valid,   ov_exp);
        check("done",        done,        dn_exp);
        if (!((ms == 2) && (m_d >= N + 2) && (m_d < 3 * N + 2)))
            check("out_data", out_data, m_out);

        if (arr_readout) begin
            if (j_ro_first < 0) j_ro_first = cyc;
            j_ro_cnt++;
        end
        if (out_valid && j_ov_first < 0) j_ov_first = cyc;
        if (out_valid && out_ready) begin
            j_hs++;
            j_words.push_back(out_data);
        end
        if (done) j_done++;
        if ((arr_in1 | arr_in2) != 8'h00) j_nz++;

        if (!rst_n || !ena) begin
            ms = 0; m_nb = 0; m_hs = 0; m_op1 = 0;
            m_pin1 = 0; m_pin2 = 0; m_out = 0;
        end else begin
            m_pin1 = 0; m_pin2 = 0;
            case (ms)
                0: if (start) begin
                    ms = 1; m_nb = 0; m_acc = 0; m_hs = 0;
                    j_ro_first = -1; j_ro_cnt = 0; j_ov_first = -1;
                    j_hs = 0; j_done = 0; j_nz = 0; j_words.delete();
                end
                1: if (in_valid) begin
                    if (m_nb % 2 == 0) m_op1 = in_data;
                    else begin
                        m_pin1 = m_op1; m_pin2 = in_data;
                        m_acc  = m_acc | (m_op1 & in_data);
                    end
                    m_nb++;
                    if (m_nb == 2 * P) begin ms = 2; m_d = 1; j_ta = cyc; end
                end
                default: begin
                    if (ov_exp && out_ready) begin
                        if (m_hs == N - 1) ms = 0;
                        else m_hs++;
                    end
                    m_d++;
                    if (m_d == 3 * N + 2) m_out = m_acc;
                end
            endcase
        end
    end

    // out_ready: 0 = always high, 1 = pattern 1,0,0 repeating, 2 = random
    initial begin
        int k;
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
        end
    end

    // bytes: b0 in [7:0]; gaps: idle cycles before byte i in nibble i
    task automatic run_job(input logic [31:0] bytes, input logic [15:0] gaps, input bit rnd_gap,
                           input int mode, input int kill_at, input bit kill_ena);
        int n;
        rdy_mode = mode;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = rnd_gap ? int'($urandom_range(0, 3)) : int'(gaps[i*4 +: 4]);
            repeat (g) begin
                in_valid = 1'b0; in_data = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_data = bytes[i*8 +: 8];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (kill_at > 0) begin
            repeat (kill_at) begin @(posedge clk); #1; end
            if (kill_ena) ena = 1'b0; else rst_n = 1'b0;
            @(posedge clk); #1;
            ena = 1'b1; rst_n = 1'b1;
            check("kill_busy",      busy,        0);
            check("kill_in_ready",  in_ready,    0);
            check("kill_out_valid", out_valid,   0);
            check("kill_readout",   arr_readout, 0);
            check("kill_out_data",  out_data,    0);
            check("kill_arr_in1",   arr_in1,     0);
            check("kill_done",      done,        0);
        end else begin
            n = 0;
            // junk start / in_valid while busy must be ignored
            while (ms != 0 && n < 500) begin
                start = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_data = 8'($urandom);
                @(posedge clk); #1;
                n++;
            end
            start = 1'b0; in_valid = 1'b0;
            check("job_timeout", n < 500, 1);
        end
    endtask

    task automatic check_words(input string nm, input logic [7:0] w);
        check({nm, "_handshakes"}, j_hs, 8);
        check({nm, "_done_pulses"}, j_done, 1);
        foreach (j_words[k]) check({nm, "_word"}, j_words[k], w);
    endtask

    task automatic check_timing(input string nm);
        check({nm, "_readout_start"}, j_ro_first - j_ta, 10);
        check({nm, "_readout_len"},   j_ro_cnt, 16);
        check({nm, "_first_valid"},   j_ov_first - j_ta, 26);
    endtask

    initial begin
        logic [31:0] b;
        logic [7:0]  w;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_busy",      busy,        0);
        check("rst_in_ready",  in_ready,    0);
        check("rst_out_valid", out_valid,   0);
        check("rst_out_data",  out_data,    0);
        check("rst_readout",   arr_readout, 0);
        check("rst_arr_in2",   arr_in2,     0);
        @(posedge clk); #1;

        run_job(32'h0000_0FFF, 16'h0000, 0, 0, 0, 0);
        check_words("single", 8'h0F);
        check_timing("single");
        check("single_pair_cycles", j_nz, 1);

        run_job(32'h0000_0000, 16'h0000, 0, 0, 0, 0);
        check_words("clear", 8'h00);

        run_job(32'h0F05_FFA0, 16'h0000, 0, 0, 0, 0);
        check_words("lanes", 8'hA5);
        check_timing("lanes");

        run_job(32'h0F05_FFA0, 16'h0000, 0, 1, 0, 0);
        check_words("backpressure", 8'hA5);

        run_job(32'h0000_0FFF, 16'h0030, 0, 0, 0, 0);
        check_words("gaps", 8'h0F);
        check("gaps_pair_cycles", j_nz, 1);

        run_job(32'h0000_0FFF, 16'h0000, 0, 0, 12, 0);
        run_job(32'h0000_0FFF, 16'h0000, 0, 0, 0, 0);
        check_words("after_reset", 8'h0F);

        run_job(32'h0F05_FFA0, 16'h0000, 0, 0, 3, 1);
        run_job(32'h0F05_FFA0, 16'h0000, 0, 2, 0, 0);
        check_words("after_ena", 8'hA5);

        for (int r = 0; r < 10; r++) begin
            b = $urandom;
            w = (b[7:0] & b[15:8]) | (b[23:16] & b[31:24]);
            run_job(b, 16'h0000, 1, r % 3, 0, 0);
            check_words("random", w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
